// File: rtl/race_pkg.sv
// Shared types and player indices for the LED racer controller.
package race_pkg;

    typedef enum logic [1:0] {
        ST_MENU      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACE      = 2'd2,
        ST_FINISH    = 2'd3
    } state_e;

    localparam int P_GREEN     = 0;
    localparam int P_RED       = 1;
    localparam int P_BLUE      = 2;
    localparam int P_YELLOW    = 3;
    localparam int NUM_PLAYERS = 4;

endpackage

// File: rtl/race_sequencer_if.sv
// Button/timebase inputs and display-facing outputs of the race controller.
interface race_sequencer_if #(
    parameter int POS_W = 7
);
    logic             tick;
    logic             start_press;
    logic [3:0]       press;
    logic             is_in_menu;
    logic [2:0]       countdown;
    logic             racing;
    logic [POS_W-1:0] green_cur_pos;
    logic [POS_W-1:0] red_cur_pos;
    logic [POS_W-1:0] blue_cur_pos;
    logic [POS_W-1:0] yellow_cur_pos;
    logic [3:0]       winner;

    modport master (
        output tick, start_press, press,
        input  is_in_menu, countdown, racing,
        input  green_cur_pos, red_cur_pos, blue_cur_pos, yellow_cur_pos, winner
    );

    modport slave (
        input  tick, start_press, press,
        output is_in_menu, countdown, racing,
        output green_cur_pos, red_cur_pos, blue_cur_pos, yellow_cur_pos, winner
    );
endinterface

// File: rtl/player_pos_counter.sv
// One player's track position: saturates at the finish LED, cleared when a race ends.
module player_pos_counter #(
    parameter int MAX_POS = 109,
    localparam int POS_W  = $clog2(MAX_POS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc_en,
    output logic             at_finish,
    output logic [POS_W-1:0] pos
);
    logic [POS_W-1:0] r_pos;

    assign at_finish = (r_pos == POS_W'(MAX_POS - 1));
    assign pos       = r_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= '0;
        end else if (clear) begin
            r_pos <= '0;
        end else if (inc_en && !at_finish) begin
            r_pos <= r_pos + 1'b1;
        end
    end
endmodule

// File: rtl/race_sequencer.sv
// Game controller: MENU -> COUNTDOWN -> RACE -> FINISH, with winner detection
// and a timed hold of the result before returning to the menu.
module race_sequencer
    import race_pkg::*;
#(
    parameter int MAX_POS        = 109,
    parameter int COUNT_FROM     = 3,
    parameter int WIN_HOLD_TICKS = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    race_sequencer_if.slave bus
);
    localparam int POS_W  = $clog2(MAX_POS);
    localparam int HOLD_W = $clog2(WIN_HOLD_TICKS + 1);

    state_e              r_state, w_state_next;
    logic [2:0]          r_countdown, w_countdown_next;
    logic [HOLD_W-1:0]   r_hold, w_hold_next;
    logic [HOLD_W-1:0]   w_hold_inc;
    logic [3:0]          r_winner, w_winner_next;
    logic                w_clear;
    logic [3:0]          w_inc_en;
    logic [3:0]          w_at_finish;
    logic [POS_W-1:0]    w_pos [NUM_PLAYERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            player_pos_counter #(.MAX_POS(MAX_POS)) u_pos (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear     (w_clear),
                .inc_en    (w_inc_en[gi]),
                .at_finish (w_at_finish[gi]),
                .pos       (w_pos[gi])
            );
        end
    endgenerate

    assign w_hold_inc = r_hold + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_MENU;
            r_countdown <= '0;
            r_hold      <= '0;
            r_winner    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_countdown <= w_countdown_next;
            r_hold      <= w_hold_next;
            r_winner    <= w_winner_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_countdown_next = r_countdown;
        w_hold_next      = r_hold;
        w_winner_next    = r_winner;
        w_clear          = 1'b0;
        w_inc_en         = '0;
        case (r_state)
            ST_MENU: begin
                // A coincident tick is deliberately not applied to the fresh count.
                if (bus.start_press) begin
                    w_state_next     = ST_COUNTDOWN;
                    w_countdown_next = 3'(COUNT_FROM);
                end
            end
            ST_COUNTDOWN: begin
                if (bus.tick) begin
                    if (r_countdown == 3'd1) begin
                        w_state_next     = ST_RACE;
                        w_countdown_next = '0;
                    end else begin
                        w_countdown_next = r_countdown - 3'd1;
                    end
                end
            end
            ST_RACE: begin
                if (|w_at_finish) begin
                    w_state_next  = ST_FINISH;
                    w_winner_next = w_at_finish;
                end else begin
                    w_inc_en = bus.press;
                end
            end
            ST_FINISH: begin
                if (bus.start_press || (bus.tick && w_hold_inc == HOLD_W'(WIN_HOLD_TICKS))) begin
                    w_state_next  = ST_MENU;
                    w_hold_next   = '0;
                    w_winner_next = '0;
                    w_clear       = 1'b1;
                end else if (bus.tick) begin
                    w_hold_next = w_hold_inc;
                end
            end
            default: begin
                w_state_next     = ST_MENU;
                w_countdown_next = '0;
                w_hold_next      = '0;
                w_winner_next    = '0;
                w_clear          = 1'b1;
            end
        endcase
    end

    assign bus.is_in_menu     = (r_state == ST_MENU);
    assign bus.racing         = (r_state == ST_RACE);
    assign bus.countdown      = r_countdown;
    assign bus.winner         = r_winner;
    assign bus.green_cur_pos  = w_pos[P_GREEN];
    assign bus.red_cur_pos    = w_pos[P_RED];
    assign bus.blue_cur_pos   = w_pos[P_BLUE];
    assign bus.yellow_cur_pos = w_pos[P_YELLOW];
endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for the race controller: countdown, single and tied wins,
// hold/exit paths, simultaneous four-player pressing and mid-race reset.
module tb_race_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    race_sequencer_if #(.POS_W(7)) bus ();

    race_sequencer #(
        .MAX_POS        (109),
        .COUNT_FROM     (3),
        .WIN_HOLD_TICKS (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.tick        = 1'b0;
        bus.start_press = 1'b0;
        bus.press       = 4'b0000;
        rst_n           = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic go_race();
        bus.start_press = 1'b1;
        step();
        bus.start_press = 1'b0;
        bus.tick        = 1'b1;
        repeat (3) step();
        bus.tick = 1'b0;
    endtask

    task automatic tick_n(input int n);
        bus.tick = 1'b1;
        repeat (n) step();
        bus.tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus.is_in_menu !== 1'b1 || bus.racing !== 1'b0 || bus.countdown !== 3'd0 || bus.winner !== 4'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: menu=%b racing=%b cd=%0d win=%b, required 1 0 0 0000",
                     bus.is_in_menu, bus.racing, bus.countdown, bus.winner);
        end
        n_cmp++;
        if ({bus.green_cur_pos, bus.red_cur_pos, bus.blue_cur_pos, bus.yellow_cur_pos} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_pos: g=%0d r=%0d b=%0d y=%0d, required all 0",
                     bus.green_cur_pos, bus.red_cur_pos, bus.blue_cur_pos, bus.yellow_cur_pos);
        end
        $display("test_reset done");
    endtask

    task automatic test_countdown();
        logic [2:0] exp_cd [3];
        exp_cd[0] = 3'd3; exp_cd[1] = 3'd2; exp_cd[2] = 3'd1;
        do_reset();
        // start and tick together: the count must load at 3, not 2
        bus.start_press = 1'b1;
        bus.tick        = 1'b1;
        bus.press       = 4'b1111;
        step();
        bus.start_press = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.countdown !== exp_cd[i] || bus.is_in_menu !== 1'b0) begin
                n_err++;
                $display("FAIL countdown_%0d: cd=%0d menu=%b, required %0d 0", i, bus.countdown, bus.is_in_menu, exp_cd[i]);
            end
            step();
        end
        bus.tick  = 1'b0;
        bus.press = 4'b0000;
        n_cmp++;
        if (bus.racing !== 1'b1 || bus.countdown !== 3'd0) begin
            n_err++;
            $display("FAIL race_entry: racing=%b cd=%0d, required 1 0", bus.racing, bus.countdown);
        end
        n_cmp++;
        if ({bus.green_cur_pos, bus.red_cur_pos, bus.blue_cur_pos, bus.yellow_cur_pos} !== 28'd0) begin
            n_err++;
            $display("FAIL no_false_start: g=%0d r=%0d b=%0d y=%0d, required all 0",
                     bus.green_cur_pos, bus.red_cur_pos, bus.blue_cur_pos, bus.yellow_cur_pos);
        end
        $display("test_countdown done");
    endtask

    task automatic test_single_winner();
        do_reset();
        go_race();
        bus.press = 4'b0010;
        repeat (108) step();
        bus.press = 4'b0000;
        n_cmp++;
        if (bus.red_cur_pos !== 7'd108 || bus.racing !== 1'b1 || bus.winner !== 4'd0) begin
            n_err++;
            $display("FAIL red_reach: red=%0d racing=%b win=%b, required 108 1 0000", bus.red_cur_pos, bus.racing, bus.winner);
        end
        step();
        n_cmp++;
        if (bus.racing !== 1'b0 || bus.winner !== 4'b0010 || bus.is_in_menu !== 1'b0) begin
            n_err++;
            $display("FAIL red_finish: racing=%b win=%b menu=%b, required 0 0010 0", bus.racing, bus.winner, bus.is_in_menu);
        end
        bus.press = 4'b0010;
        step();
        bus.press = 4'b0000;
        n_cmp++;
        if (bus.red_cur_pos !== 7'd108) begin
            n_err++;
            $display("FAIL red_saturate: red=%0d, required 108", bus.red_cur_pos);
        end
        // hold counter starts at 0: four ticks keep FINISH, the fifth returns to MENU
        tick_n(4);
        n_cmp++;
        if (bus.is_in_menu !== 1'b0 || bus.winner !== 4'b0010) begin
            n_err++;
            $display("FAIL hold_4: menu=%b win=%b, required 0 0010", bus.is_in_menu, bus.winner);
        end
        tick_n(1);
        n_cmp++;
        if (bus.is_in_menu !== 1'b1 || bus.winner !== 4'd0 || bus.red_cur_pos !== 7'd0) begin
            n_err++;
            $display("FAIL hold_exit: menu=%b win=%b red=%0d, required 1 0000 0", bus.is_in_menu, bus.winner, bus.red_cur_pos);
        end
        $display("test_single_winner done");
    endtask

    task automatic test_tie();
        do_reset();
        go_race();
        bus.press = 4'b0001;
        repeat (107) step();
        bus.press = 4'b0100;
        repeat (107) step();
        bus.press = 4'b0000;
        n_cmp++;
        if (bus.green_cur_pos !== 7'd107 || bus.blue_cur_pos !== 7'd107 || bus.red_cur_pos !== 7'd0) begin
            n_err++;
            $display("FAIL tie_setup: g=%0d b=%0d r=%0d, required 107 107 0", bus.green_cur_pos, bus.blue_cur_pos, bus.red_cur_pos);
        end
        bus.press = 4'b0101;
        step();
        bus.press = 4'b0000;
        step();
        n_cmp++;
        if (bus.winner !== 4'b0101 || bus.green_cur_pos !== 7'd108 || bus.blue_cur_pos !== 7'd108) begin
            n_err++;
            $display("FAIL tie_winner: win=%b g=%0d b=%0d, required 0101 108 108", bus.winner, bus.green_cur_pos, bus.blue_cur_pos);
        end
        tick_n(2);
        bus.start_press = 1'b1;
        step();
        bus.start_press = 1'b0;
        n_cmp++;
        if (bus.is_in_menu !== 1'b1 || bus.winner !== 4'd0 ||
            {bus.green_cur_pos, bus.red_cur_pos, bus.blue_cur_pos, bus.yellow_cur_pos} !== 28'd0) begin
            n_err++;
            $display("FAIL start_exit: menu=%b win=%b g=%0d b=%0d, required 1 0000 0 0",
                     bus.is_in_menu, bus.winner, bus.green_cur_pos, bus.blue_cur_pos);
        end
        $display("test_tie done");
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        go_race();
        bad = 0;
        bus.press = 4'b1111;
        for (int i = 1; i <= 108; i++) begin
            step();
            if (bus.green_cur_pos != 7'(i) || bus.red_cur_pos != 7'(i) ||
                bus.blue_cur_pos != 7'(i) || bus.yellow_cur_pos != 7'(i)) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL all_lockstep: %0d bad cycles, required 0", bad);
        end
        step();
        bus.press = 4'b0000;
        n_cmp++;
        if (bus.winner !== 4'b1111 || bus.racing !== 1'b0 || bus.yellow_cur_pos !== 7'd108) begin
            n_err++;
            $display("FAIL all_winner: win=%b racing=%b y=%0d, required 1111 0 108", bus.winner, bus.racing, bus.yellow_cur_pos);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_midrace();
        do_reset();
        go_race();
        bus.press = 4'b1000;
        repeat (50) step();
        bus.press = 4'b0000;
        n_cmp++;
        if (bus.yellow_cur_pos !== 7'd50) begin
            n_err++;
            $display("FAIL yellow_50: y=%0d, required 50", bus.yellow_cur_pos);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.yellow_cur_pos !== 7'd0 || bus.is_in_menu !== 1'b1 || bus.racing !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: y=%0d menu=%b racing=%b, required 0 1 0", bus.yellow_cur_pos, bus.is_in_menu, bus.racing);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset_midrace done");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        test_reset();
        test_countdown();
        test_single_winner();
        test_tie();
        test_back_to_back();
        test_reset_midrace();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
